vending_machine_param: RTL
==========================

# vending_machine_param

Parametrised successor to the single-price vending controller. Accepts 5c/10c/25c coins into a credit register, vends one item when credit reaches a configurable price, and returns change one 5c unit per cycle. It also tracks a stock counter, supports cancel/refund, and rejects coins it cannot hold. It sits between the coin-slot front end and the dispense/change actuators.

## Interface
Parameters:
- PRICE_UNITS, 3: item price in 5c units (3 = 15c); legal range 1 .. 2^CREDIT_W-1.
- CREDIT_W, 5: credit register width in 5c units (max credit 31 units = 155c).
- STOCK_W, 4: stock counter width.
- STOCK_INIT, 8: stock value loaded at reset and on restock; must be ≤ 2^STOCK_W-1.

Ports:
- clk, input, 1: rising-edge clock; single clock domain.
- rst, input, 1: asynchronous, active-high reset.
- coin, input, 2: coin code, sampled every edge: 00 none, 01 5c (1 unit), 10 10c (2 units), 11 25c (5 units).
- cancel, input, 1: refund request, level sampled each edge.
- restock, input, 1: reload stock to STOCK_INIT.
- nw_pa, output, 1: vend strobe, one cycle per item.
- change_out, output, 1: one 5c unit returned per asserted cycle.
- coin_reject, output, 1: one-cycle pulse, the cycle after a rejected coin.
- busy, output, 1: high in VEND or CHANGE.
- sold_out, output, 1: stock == 0.
- credit, output, CREDIT_W: current credit in units.

## Operation
- States: IDLE, VEND, CHANGE. Reset: state IDLE, credit 0, stock STOCK_INIT. nw_pa, change_out, coin_reject and busy are 0; sold_out is 0 (given STOCK_INIT > 0).
- IDLE, coin ≠ 00: accept if not sold_out, cancel low and credit + value ≤ 2^CREDIT_W-1. On accept, credit += value. Otherwise credit is unchanged and coin_reject pulses.
- IDLE, credit ≥ PRICE_UNITS and stock > 0: go to VEND. This check uses the registered credit and takes priority over coin acceptance in the same cycle; that coin is rejected.
- VEND, exactly one cycle: nw_pa = 1, credit -= PRICE_UNITS, stock -= 1. Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE: change_out = 1 each cycle and credit -= 1. Return to IDLE on the cycle credit becomes 0.
- cancel in IDLE with credit > 0: go to CHANGE (full refund). Cancel with credit 0 does nothing. Cancel in VEND/CHANGE is ignored.
- cancel and coin in the same cycle in IDLE: cancel wins and the coin is rejected.
- Any coin during VEND or CHANGE is rejected.
- sold_out: all coins are rejected. Credit already held stays until cancel.
- restock is honoured only in IDLE with no simultaneous vend decision. It is ignored otherwise.
- nw_pa, change_out and busy are decoded from the state register only; there is no combinational input-to-output path. coin_reject is a registered flag.
- Arithmetic is unsigned. The acceptance check is computed at CREDIT_W+1 bits so it cannot wrap. Credit never underflows: the VEND and CHANGE guards above prevent it.

## Timing
- Coin sampled at edge N → credit updated after N; coin_reject, if any, is high in cycle N+1.
- Credit reaching the price after edge N → VEND (nw_pa high) in cycle N+2, i.e. 2-cycle vend latency from the final coin.
- Change of k units → k consecutive change_out cycles immediately after VEND; busy is high for k+1 cycles.
- Refund of k units → CHANGE starts the cycle after cancel is sampled; k cycles of change_out.
- rst mid-VEND/CHANGE: immediate return to reset values; credit in flight is discarded and no further change is issued.

## Structure
- Package vm_pkg holds:
  - coin code localparams COIN_NONE/5/10/25;
  - the unit-value function (code → 3-bit units);
  - the state encoding for IDLE/VEND/CHANGE.
- One sub-module, vm_coin_decode: combinational code → units plus a valid flag. All sequential logic stays in vending_machine_param.

## Test plan
- Defaults; 5c, 5c, 5c spaced by idle cycles → one nw_pa pulse 2 cycles after the third coin; credit returns to 0; no change_out.
- 5c, 5c, 10c (20c) → nw_pa once, then change_out for 1 cycle, then IDLE with credit 0.
- 25c then cancel before vend completes → vends (credit 5 ≥ 3), cancel ignored, then 2 change_out cycles. Separately, 10c then cancel → 2 change_out cycles, no nw_pa.
- CREDIT_W=3, PRICE_UNITS=7: 25c, then 10c (5+2=7 ≤ 7) accepted → vend; separately 25c then 25c (10 > 7) → coin_reject pulse, credit stays at 5.
- STOCK_INIT=1: first purchase → sold_out=1. Next 5c → coin_reject. restock → sold_out=0 and stock=1.
- Assert rst during CHANGE with 3 units pending → all outputs 0 and credit 0 while rst is high; no change_out after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the parametrised vending controller:
// coin codes, coin unit values and the controller state encoding.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    // Coin code to value in 5c units.
    function automatic logic [2:0] coin_units(input logic [1:0] code);
        logic [2:0] u;
        u = 3'd0;
        case (code)
            COIN_5:  u = 3'd1;
            COIN_10: u = 3'd2;
            COIN_25: u = 3'd5;
            default: u = 3'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vm_coin_decode.sv
// Coin slot decoder: code to 5c units plus a coin-present flag.
// Purely combinational.
import vm_pkg::*;

module vm_coin_decode (
    input  logic [1:0] coin_i,
    output logic [2:0] units_o,
    output logic       valid_o
);

    // Decode the raw code into its value and presence flag.
    always_comb begin
        units_o = coin_units(coin_i);
        valid_o = (coin_i != COIN_NONE);
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: coin credit, vend, change/refund,
// stock tracking and coin rejection.
import vm_pkg::*;

module vending_machine_param #(
    parameter int unsigned PRICE_UNITS = 3,
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned STOCK_W     = 4,
    parameter int unsigned STOCK_INIT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                restock,
    output logic                nw_pa,
    output logic                change_out,
    output logic                coin_reject,
    output logic                busy,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);
    localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);
    localparam logic [CREDIT_W:0]   CMAX  = {1'b0, {CREDIT_W{1'b1}}};

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                reject_q, reject_d;

    logic [2:0]          units;
    logic                coin_vld;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] remain;
    logic                vend_go;
    logic                fits;

    vm_coin_decode u_dec (
        .coin_i  (coin),
        .units_o (units),
        .valid_o (coin_vld)
    );

    // Extra bit on the sum so the acceptance check cannot wrap.
    assign sum     = {1'b0, credit_q} + (CREDIT_W+1)'(units);
    assign fits    = (sum <= CMAX);
    assign remain  = credit_q - PRICE;
    assign vend_go = (credit_q >= PRICE) && (stock_q != '0);

    // State, credit, stock and reject flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            stock_q  <= SINIT;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            reject_q <= reject_d;
        end
    end

    // Next-state and datapath update; vend beats cancel beats coin.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        reject_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (vend_go) begin
                    state_d  = ST_VEND;
                    reject_d = coin_vld;
                end else begin
                    if (restock)
                        stock_d = SINIT;
                    if (cancel) begin
                        reject_d = coin_vld;
                        if (credit_q != '0)
                            state_d = ST_CHANGE;
                    end else if (coin_vld) begin
                        if ((stock_q != '0) && fits)
                            credit_d = sum[CREDIT_W-1:0];
                        else
                            reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                reject_d = coin_vld;
                credit_d = remain;
                stock_d  = stock_q - STOCK_W'(1);
                state_d  = (remain != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_d = coin_vld;
                if (credit_q != '0)
                    credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1))
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        nw_pa       = (state_q == ST_VEND);
        change_out  = (state_q == ST_CHANGE);
        busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);
        coin_reject = reject_q;
        sold_out    = (stock_q == '0);
        credit      = credit_q;
    end

endmodule
